mult_share_ctrl: RTL and testbench

Sequencing controller that time-shares one multiplier instance among N_REQ requesters. The multiplier is the width-selected multiplier, either carry-lookahead or tree, instantiated alongside this block. Each requester issues operands over a valid/ready handshake. A round-robin arbiter grants one request at a time, holds the operands stable for MUL_LAT cycles, captures the product and returns it tagged with the requester id. Only one operation is outstanding at a time.

---
 rtl/mult_share_ctrl_pkg.sv | 21 ++
 rtl/mult_share_ctrl_if.sv | 39 +++
 rtl/mult_share_ctrl_rr_arbiter.sv | 36 +++
 rtl/mult_share_ctrl.sv | 128 ++++++++++++
 tb/tb_mult_share_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
// The controller, its arbiter and its bus interface all import this package.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bits needed to hold an index in 0..n-1, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester, multiplier and response signals of mult_share_ctrl in one bundle.
// valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
// the source holds valid and its payload stable until that edge and never waits on ready to raise valid.
interface mult_share_ctrl_if #(
  parameter int N_REQ         = 4,
  parameter int A0_WIDTH      = 32,
  parameter int A1_WIDTH      = 32,
  parameter int PRODUCT_WIDTH = 64
);
  import mult_share_pkg::*;

  localparam int ID_WIDTH = clog2(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*A0_WIDTH-1:0] req_a0;
  logic [N_REQ*A1_WIDTH-1:0] req_a1;
  logic [A0_WIDTH-1:0]       mul_a0;
  logic [A1_WIDTH-1:0]       mul_a1;
  logic [PRODUCT_WIDTH-1:0]  mul_product;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_WIDTH-1:0]       rsp_id;
  logic [PRODUCT_WIDTH-1:0]  rsp_product;
  logic                      busy;

  // Controller side.
  modport slave (
    input  req_valid, req_a0, req_a1, mul_product, rsp_ready,
    output req_ready, mul_a0, mul_a1, rsp_valid, rsp_id, rsp_product, busy
  );

  // Requesters, multiplier and response consumer side.
  modport master (
    output req_valid, req_a0, req_a1, mul_product, rsp_ready,
    input  req_ready, mul_a0, mul_a1, rsp_valid, rsp_id, rsp_product, busy
  );

endinterface

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N_REQ.
// Candidates are reduced mod N_REQ, so unused ids of a non-power-of-2 N_REQ never appear.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]    grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any_req
);

  always_comb begin
    int                  c;
    logic [ID_WIDTH-1:0] cand;
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    c       = 0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      cand = ID_WIDTH'(c);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one external multiplier among N_REQ requesters: round-robin grant,
// operands held for MUL_LAT cycles, product returned tagged with the requester id.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int A0_WIDTH      = 32,
  parameter int A1_WIDTH      = 32,
  parameter int PRODUCT_WIDTH = 64,
  parameter int MUL_LAT       = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  mult_share_ctrl_if.slave bus,
  output state_t state_dbg
);

  localparam int ID_WIDTH  = clog2(N_REQ);
  localparam int LAT_WIDTH = clog2(MUL_LAT + 1);

  state_t                   state;
  state_t                   state_next;
  logic [ID_WIDTH-1:0]      rr_ptr;
  logic [ID_WIDTH-1:0]      id_q;
  logic [LAT_WIDTH-1:0]     lat_cnt;
  logic [A0_WIDTH-1:0]      mul_a0_q;
  logic [A1_WIDTH-1:0]      mul_a1_q;
  logic                     rsp_valid_q;
  logic [ID_WIDTH-1:0]      rsp_id_q;
  logic [PRODUCT_WIDTH-1:0] rsp_product_q;

  logic [N_REQ-1:0]         arb_grant;
  logic [ID_WIDTH-1:0]      arb_idx;
  logic                     arb_any;
  logic [A0_WIDTH-1:0]      sel_a0;
  logic [A1_WIDTH-1:0]      sel_a1;
  logic                     accept;
  logic                     calc_done;
  logic                     rsp_done;

  rr_arbiter #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  always_comb begin
    sel_a0 = bus.req_a0[int'(arb_idx)*A0_WIDTH +: A0_WIDTH];
    sel_a1 = bus.req_a1[int'(arb_idx)*A1_WIDTH +: A1_WIDTH];
  end

  assign accept    = (state == IDLE) && arb_any;
  assign calc_done = (state == CALC) && (lat_cnt == LAT_WIDTH'(1));
  assign rsp_done  = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_any)        state_next = CALC;
      CALC:    if (calc_done)      state_next = RESP;
      RESP:    if (bus.rsp_ready)  state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Operands are latched on the accept edge and stay frozen until the next accept,
  // which is what lets a multi-cycle multiplier see stable inputs for all of CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a0_q <= '0;
      mul_a1_q <= '0;
      id_q     <= '0;
      lat_cnt  <= '0;
    end else if (accept) begin
      mul_a0_q <= sel_a0;
      mul_a1_q <= sel_a1;
      id_q     <= arb_idx;
      lat_cnt  <= LAT_WIDTH'(MUL_LAT);
    end else if (state == CALC) begin
      lat_cnt  <= lat_cnt - LAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else if (calc_done) begin
      rsp_valid_q   <= 1'b1;
      rsp_id_q      <= id_q;
      rsp_product_q <= bus.mul_product;
    end else if (rsp_done) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  // The pointer moves only once the response is taken, so an op lost to reset
  // does not count as a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (rsp_done) begin
      if (id_q == ID_WIDTH'(N_REQ - 1)) rr_ptr <= '0;
      else                              rr_ptr <= id_q + ID_WIDTH'(1);
    end
  end

  assign bus.req_ready   = (state == IDLE) ? arb_grant : '0;
  assign bus.mul_a0      = mul_a0_q;
  assign bus.mul_a1      = mul_a1_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.busy        = (state != IDLE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: three instances cover N_REQ=4/MUL_LAT=1,
// N_REQ=4/MUL_LAT=3 with a two-register multiplier model, and N_REQ=3.
module tb_mult_share_ctrl;
  import mult_share_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [63:0] exp_q[$];

  mult_share_ctrl_if #(.N_REQ(4), .A0_WIDTH(32), .A1_WIDTH(32), .PRODUCT_WIDTH(64)) b0 ();
  mult_share_ctrl_if #(.N_REQ(4), .A0_WIDTH(32), .A1_WIDTH(32), .PRODUCT_WIDTH(64)) b1 ();
  mult_share_ctrl_if #(.N_REQ(3), .A0_WIDTH(32), .A1_WIDTH(32), .PRODUCT_WIDTH(64)) b2 ();
  state_t st0, st1, st2;

  mult_share_ctrl #(.N_REQ(4), .A0_WIDTH(32), .A1_WIDTH(32), .PRODUCT_WIDTH(64), .MUL_LAT(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave), .state_dbg(st0));
  mult_share_ctrl #(.N_REQ(4), .A0_WIDTH(32), .A1_WIDTH(32), .PRODUCT_WIDTH(64), .MUL_LAT(3))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave), .state_dbg(st1));
  mult_share_ctrl #(.N_REQ(3), .A0_WIDTH(32), .A1_WIDTH(32), .PRODUCT_WIDTH(64), .MUL_LAT(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave), .state_dbg(st2));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier models: combinational for MUL_LAT=1, two product registers for MUL_LAT=3
  logic [63:0] p1, p2;
  assign b0.mul_product = 64'(b0.mul_a0) * 64'(b0.mul_a1);
  assign b2.mul_product = 64'(b2.mul_a0) * 64'(b2.mul_a1);
  always @(posedge clk) begin
    p1 <= 64'(b1.mul_a0) * 64'(b1.mul_a1);
    p2 <= p1;
  end
  assign b1.mul_product = p2;

  // Requester rule on u0: a pending request is not withdrawn before it is accepted
  logic [3:0] pend0;
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++)
        assert (!(pend0[i] && !b0.req_valid[i])) else $error("req_valid[%0d] dropped before ready", i);
      pend0 <= b0.req_valid & ~b0.req_ready;
    end else begin
      pend0 <= '0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic clear_inputs();
    b0.req_valid = '0; b0.req_a0 = '0; b0.req_a1 = '0; b0.rsp_ready = 1'b0;
    b1.req_valid = '0; b1.req_a0 = '0; b1.req_a1 = '0; b1.rsp_ready = 1'b0;
    b2.req_valid = '0; b2.req_a0 = '0; b2.req_a1 = '0; b2.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pend0    = '0;
    do_reset();

    // Reset state
    @(negedge clk); #1;
    check("rst_req_ready", 64'(b0.req_ready), 64'h0);
    check("rst_rsp_valid", 64'(b0.rsp_valid), 64'h0);
    check("rst_rsp_id", 64'(b0.rsp_id), 64'h0);
    check("rst_rsp_product", b0.rsp_product, 64'h0);
    check("rst_mul_a0", 64'(b0.mul_a0), 64'h0);
    check("rst_busy", 64'(b0.busy), 64'h0);
    check("rst_state", 64'(st0), 64'(IDLE));

    // Single request from requester 1: 7*6
    @(negedge clk);
    b0.req_valid = 4'b0010; b0.req_a0[32 +: 32] = 32'd7; b0.req_a1[32 +: 32] = 32'd6;
    b0.rsp_ready = 1'b1;
    #1;
    check("single_ready", 64'(b0.req_ready), 64'h2);
    check("single_busy_T", 64'(b0.busy), 64'h0);
    @(negedge clk); b0.req_valid = '0; #1;
    check("single_busy_T1", 64'(b0.busy), 64'h1);
    check("single_state_T1", 64'(st0), 64'(CALC));
    check("single_mul_a0", 64'(b0.mul_a0), 64'd7);
    check("single_mul_a1", 64'(b0.mul_a1), 64'd6);
    check("single_rsp_T1", 64'(b0.rsp_valid), 64'h0);
    @(negedge clk); #1;
    check("single_rsp_valid", 64'(b0.rsp_valid), 64'h1);
    check("single_rsp_id", 64'(b0.rsp_id), 64'h1);
    check("single_rsp_product", b0.rsp_product, 64'd42);
    check("single_busy_T2", 64'(b0.busy), 64'h1);
    @(negedge clk); #1;
    check("single_rsp_drop", 64'(b0.rsp_valid), 64'h0);
    check("single_idle", 64'(b0.busy), 64'h0);

    // Round robin with all four requesters held valid
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b0.req_a0[i*32 +: 32] = 32'(i + 3);
      b0.req_a1[i*32 +: 32] = 32'(i + 10);
    end
    b0.req_valid = 4'b1111; b0.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("rr_grant_%0d", k), 64'(b0.req_ready), 64'(1) << e);
      exp_q.push_back(64'((e + 3) * (e + 10)));
      @(negedge clk); #1;
      check($sformatf("rr_busy_%0d", k), 64'(b0.busy), 64'h1);
      @(negedge clk); #1;
      check($sformatf("rr_rsp_valid_%0d", k), 64'(b0.rsp_valid), 64'h1);
      check($sformatf("rr_rsp_id_%0d", k), 64'(b0.rsp_id), 64'(e));
      check($sformatf("rr_rsp_product_%0d", k), b0.rsp_product, exp_q.pop_front());
    end

    // Multi-cycle multiplier: FFFF_FFFF * 2
    do_reset();
    @(negedge clk);
    b1.req_valid = 4'b0001; b1.req_a0[31:0] = 32'hFFFF_FFFF; b1.req_a1[31:0] = 32'd2;
    b1.rsp_ready = 1'b1;
    #1;
    check("lat3_ready", 64'(b1.req_ready), 64'h1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      b1.req_valid = '0;
      #1;
      check($sformatf("lat3_a0_c%0d", c), 64'(b1.mul_a0), 64'hFFFF_FFFF);
      check($sformatf("lat3_a1_c%0d", c), 64'(b1.mul_a1), 64'd2);
      check($sformatf("lat3_nrsp_c%0d", c), 64'(b1.rsp_valid), 64'h0);
    end
    @(negedge clk); #1;
    check("lat3_rsp_valid", 64'(b1.rsp_valid), 64'h1);
    check("lat3_rsp_product", b1.rsp_product, 64'h1_FFFF_FFFE);
    @(negedge clk); #1;
    check("lat3_idle", 64'(b1.busy), 64'h0);

    // Backpressure: requester 0 served, requester 3 waits through a 5-cycle stall
    do_reset();
    @(negedge clk);
    b0.req_a0[0 +: 32] = 32'd5; b0.req_a1[0 +: 32] = 32'd9;
    b0.req_a0[96 +: 32] = 32'd4; b0.req_a1[96 +: 32] = 32'd4;
    b0.req_valid = 4'b1001; b0.rsp_ready = 1'b0;
    #1;
    check("bp_grant0", 64'(b0.req_ready), 64'h1);
    @(negedge clk); b0.req_valid = 4'b1000; #1;
    check("bp_calc_ready", 64'(b0.req_ready), 64'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check($sformatf("bp_valid_%0d", c), 64'(b0.rsp_valid), 64'h1);
      check($sformatf("bp_id_%0d", c), 64'(b0.rsp_id), 64'h0);
      check($sformatf("bp_product_%0d", c), b0.rsp_product, 64'd45);
      check($sformatf("bp_no_ready_%0d", c), 64'(b0.req_ready), 64'h0);
    end
    @(negedge clk); b0.rsp_ready = 1'b1; #1;
    check("bp_hs_valid", 64'(b0.rsp_valid), 64'h1);
    check("bp_hs_product", b0.rsp_product, 64'd45);
    @(negedge clk); #1;
    check("bp_next_grant", 64'(b0.req_ready), 64'h8);

    // Reset during CALC of requester 3's op
    @(negedge clk); b0.req_valid = '0; #1;
    check("mid_in_calc", 64'(st0), 64'(CALC));
    rst_n = 1'b0; #1;
    check("mid_busy", 64'(b0.busy), 64'h0);
    check("mid_mul_a0", 64'(b0.mul_a0), 64'h0);
    check("mid_mul_a1", 64'(b0.mul_a1), 64'h0);
    check("mid_rsp_valid", 64'(b0.rsp_valid), 64'h0);
    check("mid_rsp_product", b0.rsp_product, 64'h0);
    check("mid_state", 64'(st0), 64'(IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("mid_no_stale_0", 64'(b0.rsp_valid), 64'h0);
    @(negedge clk); #1;
    check("mid_no_stale_1", 64'(b0.rsp_valid), 64'h0);
    @(negedge clk);
    b0.req_a0[0 +: 32] = 32'd2; b0.req_a1[0 +: 32] = 32'd3;
    b0.req_valid = 4'b1001;
    #1;
    check("mid_restart_grant", 64'(b0.req_ready), 64'h1);
    @(negedge clk); b0.req_valid = 4'b1000; #1;
    @(negedge clk); #1;
    check("mid_restart_id", 64'(b0.rsp_id), 64'h0);
    check("mid_restart_product", b0.rsp_product, 64'd6);

    // N_REQ=3: grant 2, then wrap to 0
    do_reset();
    @(negedge clk);
    b2.req_a0[64 +: 32] = 32'd11; b2.req_a1[64 +: 32] = 32'd13;
    b2.req_valid = 3'b100; b2.rsp_ready = 1'b1;
    #1;
    check("n3_grant2", 64'(b2.req_ready), 64'h4);
    @(negedge clk); b2.req_valid = '0; #1;
    @(negedge clk); #1;
    check("n3_rsp_id2", 64'(b2.rsp_id), 64'h2);
    check("n3_rsp_product2", b2.rsp_product, 64'd143);
    @(negedge clk);
    b2.req_a0[0 +: 32] = 32'd3; b2.req_a1[0 +: 32] = 32'd5;
    b2.req_valid = 3'b001;
    #1;
    check("n3_grant0", 64'(b2.req_ready), 64'h1);
    @(negedge clk); b2.req_valid = '0; #1;
    @(negedge clk); #1;
    check("n3_rsp_id0", 64'(b2.rsp_id), 64'h0);
    check("n3_rsp_product0", b2.rsp_product, 64'd15);

    do_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
